neuron_acc: RTL and testbench
=============================

NEURON_ACC -- requirements
Module: neuron_acc

Interface
REQ-001 The block SHALL have parameter MAX_TERMS, default 16, meaning the maximum number of (w,x) terms per dot product; legal range 1..16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning w/x/b/in_last are valid this cycle.
REQ-005 The block SHALL have port in_ready, output, 1, meaning a term is accepted when in_valid and in_ready are both high.
REQ-006 The block SHALL have ports w and x, input, 8 each, signed Q1.6 weight and activation (64 = 1.0).
REQ-007 The block SHALL have port b, input, 8, signed Q1.6 bias, sampled only with the first term of a dot product.
REQ-008 The block SHALL have port in_last, input, 1, marking the final term of the current dot product.
REQ-009 The block SHALL have port out_valid, output, 1, meaning out/ovr/cnt hold a result.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result when out_valid is also high.
REQ-011 The block SHALL have port out, output, 8, the signed Q1.6 result.
REQ-012 The block SHALL have port ovr, output, 1, set when out was saturated.
REQ-013 The block SHALL have port cnt, output, 5, the number of terms accumulated into the current result.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM, FINISH, OUTPUT.
REQ-015 IDLE: in_ready=1; an accepted term stores b, loads acc with w*x, sets cnt=1, and goes to FINISH if in_last or MAX_TERMS=1, else to ACCUM.
REQ-016 ACCUM: in_ready=1; each accepted term adds w*x to acc and increments cnt; go to FINISH when in_last or cnt reaches MAX_TERMS; idle cycles (in_valid=0) hold state.
REQ-017 Products SHALL be full-precision 16-bit signed (Q2.12); acc SHALL be 20-bit signed and never wraps for MAX_TERMS<=16.
REQ-018 FINISH (one cycle, in_ready=0): sum = acc + (sign-extended b << 6); result = sum arithmetically shifted right by 6 (floor); saturate to [-128,127], setting ovr=1 on clamp, else ovr=0; register out/ovr/cnt; go to OUTPUT.
REQ-019 OUTPUT: out_valid=1, in_ready=0, out/ovr/cnt stable until out_ready=1, then return to IDLE with out_valid=0 the next cycle.
REQ-020 Latency SHALL be exactly 2 cycles: last term accepted at edge T, out_valid high after edge T+2.
REQ-021 Reaching MAX_TERMS without in_last SHALL force FINISH; the following term starts a new dot product.
REQ-022 in_last asserted with in_valid=0 SHALL be ignored.

Reset
REQ-023 Asserting rst SHALL immediately force IDLE, acc=0, cnt=0, out=0, ovr=0, out_valid=0, in_ready=1 when released, discarding any partial sum or pending result.
REQ-024 The first clk edge after rst deasserts SHALL be able to accept a term.

Configuration
REQ-025 With macro NEURON_ACC_RELU_EN defined, FINISH SHALL replace a negative saturated result with 0 and clear ovr if the clamp was to -128.
REQ-026 Without NEURON_ACC_RELU_EN, the result SHALL be the signed saturated value as in REQ-018.

Verification
REQ-027 Single term w=64, x=32, b=16, in_last=1 -> out=48 (0x30), ovr=0, cnt=1, out_valid 2 cycles after acceptance.
REQ-028 Four terms w=127, x=127, b=0, last on fourth -> sum 64516, out=127, ovr=1, cnt=4.
REQ-029 Two terms w=-128, x=127, b=0 -> out=-128 (0x80), ovr=1 without RELU; out=0, ovr=0 with NEURON_ACC_RELU_EN.
REQ-030 w=-64, x=64, b=0 single term -> out=0xC0 without RELU, 0x00 with RELU; then out_ready held low 3 cycles -> out/out_valid stable, in_ready=0 throughout.
REQ-031 MAX_TERMS=4, five terms with in_last only on fifth, each w=64, x=64 -> first result out=127, ovr=1, cnt=4; second result out=64, cnt=1.
REQ-032 rst pulsed after two of three terms accepted -> out_valid=0, cnt=0 immediately; new single term w=64, x=64, b=0 -> out=64.

Source files
------------

// File: rtl/neuron_acc.sv
// neuron_acc: streaming Q1.6 dot-product accumulator with bias, saturating
// Q1.6 result and valid/ready handshakes on both sides.
// Optional feature: define NEURON_ACC_RELU_EN to clamp negative results to 0.
// out_valid is a registered flag raised one cycle after entering OUTPUT, so
// the result appears two edges after the last term is accepted.
module neuron_acc #(
    parameter int MAX_TERMS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] w,
    input  logic [7:0] x,
    input  logic [7:0] b,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out,
    output logic       ovr,
    output logic [4:0] cnt
);

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH, OUTPUT} state_t;

    state_t             state;
    state_t             nxt;
    logic signed [19:0] acc;
    logic        [7:0]  bias;
    logic        [4:0]  tcnt;
    logic        [4:0]  tcnt_nxt;
    logic               accept;
    logic               last_term;
    logic signed [15:0] prod;
    logic signed [19:0] prod_ext;
    logic signed [19:0] bias_ext;
    logic signed [19:0] sum;
    logic signed [19:0] shr;
    logic        [7:0]  sat_out;
    logic               sat_ovr;

    // Term handshake and full-precision Q2.12 product
    assign accept    = in_valid && in_ready;
    assign prod      = $signed(w) * $signed(x);
    assign prod_ext  = {{4{prod[15]}}, prod};
    assign tcnt_nxt  = (state == IDLE) ? 5'd1 : tcnt + 5'd1;
    assign last_term = in_last || (tcnt_nxt == 5'(MAX_TERMS));

    // Bias alignment, floor shift back to Q1.6 and saturation
    always_comb begin
        bias_ext = {{6{bias[7]}}, bias, 6'b0};
        sum      = acc + bias_ext;
        shr      = sum >>> 6;
        sat_out  = shr[7:0];
        sat_ovr  = 1'b0;
        if (shr > 20'sd127) begin
            sat_out = 8'h7f;
            sat_ovr = 1'b1;
        end else if (shr < -20'sd128) begin
            sat_out = 8'h80;
            sat_ovr = 1'b1;
        end
`ifdef NEURON_ACC_RELU_EN
        if (sat_out[7]) begin
            sat_out = '0;
            sat_ovr = 1'b0;
        end
`endif
    end

    // Next-state and handshake outputs
    always_comb begin
        nxt      = state;
        in_ready = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                if (in_valid)
                    nxt = last_term ? FINISH : ACCUM;
            end
            FINISH:  nxt = OUTPUT;
            OUTPUT:  if (out_valid && out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State register and delayed result-valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            state <= nxt;
            if (state == OUTPUT && !out_valid)
                out_valid <= 1'b1;
            else if (out_valid && out_ready)
                out_valid <= 1'b0;
        end
    end

    // Accumulator, bias capture and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            bias <= '0;
            tcnt <= '0;
            out  <= '0;
            ovr  <= 1'b0;
            cnt  <= '0;
        end else begin
            if (accept) begin
                tcnt <= tcnt_nxt;
                if (state == IDLE) begin
                    acc  <= prod_ext;
                    bias <= b;
                end else begin
                    acc <= acc + prod_ext;
                end
            end
            if (state == FINISH) begin
                out <= sat_out;
                ovr <= sat_ovr;
                cnt <= tcnt;
            end
        end
    end

endmodule

// File: tb/tb_neuron_acc.sv
// Directed bench for neuron_acc: a vector table for single dot products and
// hand-written sequences for stall, MAX_TERMS wrap, idle gaps and reset.
module tb_neuron_acc;

`ifdef NEURON_ACC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic       sel;
    logic [7:0] w, x, b;

    logic       in_ready0, out_valid0, ovr0;
    logic [7:0] out0;
    logic [4:0] cnt0;
    logic       in_ready4, out_valid4, ovr4;
    logic [7:0] out4;
    logic [4:0] cnt4;

    logic       in_ready_m, out_valid_m, ovr_m;
    logic [7:0] out_m;
    logic [4:0] cnt_m;

    assign in_ready_m  = sel ? in_ready4  : in_ready0;
    assign out_valid_m = sel ? out_valid4 : out_valid0;
    assign ovr_m       = sel ? ovr4       : ovr0;
    assign out_m       = sel ? out4       : out0;
    assign cnt_m       = sel ? cnt4       : cnt0;

    neuron_acc dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && !sel), .in_ready(in_ready0),
        .w(w), .x(x), .b(b), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready && !sel),
        .out(out0), .ovr(ovr0), .cnt(cnt0)
    );

    neuron_acc #(.MAX_TERMS(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel), .in_ready(in_ready4),
        .w(w), .x(x), .b(b), .in_last(in_last),
        .out_valid(out_valid4), .out_ready(out_ready && sel),
        .out(out4), .ovr(ovr4), .cnt(cnt4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] tw, input logic [7:0] tx,
                        input logic [7:0] tb, input logic tl);
        chk("in_ready_before_term", int'(in_ready_m), 1);
        in_valid = 1'b1;
        w = tw; x = tx; b = tb; in_last = tl;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called just after the edge that accepted the last term.
    task automatic result(input string nm, input logic [7:0] eout,
                          input logic eovr, input logic [4:0] ecnt);
        chk({nm, "_valid_T0"}, int'(out_valid_m), 0);
        @(posedge clk); #1;
        chk({nm, "_valid_T1"}, int'(out_valid_m), 0);
        @(posedge clk); #1;
        chk({nm, "_valid_T2"}, int'(out_valid_m), 1);
        chk({nm, "_out"}, int'(out_m), int'(eout));
        chk({nm, "_ovr"}, int'(ovr_m), int'(eovr));
        chk({nm, "_cnt"}, int'(cnt_m), int'(ecnt));
        chk({nm, "_in_ready_busy"}, int'(in_ready_m), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_valid_after"}, int'(out_valid_m), 0);
        chk({nm, "_in_ready_after"}, int'(in_ready_m), 1);
    endtask

    typedef struct {
        string      name;
        int         n;
        logic [7:0] w;
        logic [7:0] x;
        logic [7:0] b;
        logic [7:0] eout;
        logic       eovr;
        logic [4:0] ecnt;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{"single",    1, 8'd64,  8'd32,  8'd16,  8'd48,                  1'b0,  5'd1};
        vt[1] = '{"four_sat",  4, 8'd127, 8'd127, 8'd0,   8'h7f,                  1'b1,  5'd4};
        vt[2] = '{"neg_clamp", 2, 8'h80,  8'd127, 8'd0,   RELU ? 8'h00 : 8'h80,   !RELU, 5'd2};
        vt[3] = '{"neg_half",  1, 8'hc0,  8'd64,  8'd0,   RELU ? 8'h00 : 8'hc0,   1'b0,  5'd1};
        vt[4] = '{"floor_pos", 1, 8'd1,   8'd1,   8'd0,   8'h00,                  1'b0,  5'd1};
        vt[5] = '{"floor_neg", 1, 8'hff,  8'd1,   8'd0,   RELU ? 8'h00 : 8'hff,   1'b0,  5'd1};
        vt[6] = '{"edge_pos",  1, 8'd127, 8'd64,  8'd0,   8'h7f,                  1'b0,  5'd1};
        vt[7] = '{"edge_neg",  1, 8'h80,  8'd64,  8'd0,   RELU ? 8'h00 : 8'h80,   1'b0,  5'd1};
        vt[8] = '{"bias_neg",  3, 8'd64,  8'd64,  8'hc0,  8'h7f,                  1'b1,  5'd3};
        vt[9] = '{"sixteen",  16, 8'h80,  8'h80,  8'h80,  8'h7f,                  1'b1,  5'd16};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        sel = 1'b0; w = '0; x = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid_m), 0);
        chk("rst_out", int'(out_m), 0);
        chk("rst_ovr", int'(ovr_m), 0);
        chk("rst_cnt", int'(cnt_m), 0);
        rst = 1'b0;
        chk("rst_in_ready", int'(in_ready_m), 1);

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < vt[i].n; k++)
                send(vt[i].w, vt[i].x, vt[i].b, k == vt[i].n - 1);
            result(vt[i].name, vt[i].eout, vt[i].eovr, vt[i].ecnt);
        end

        // Bias only taken from the first term: 2048 + 0 + (16<<6) -> 48
        send(8'd64, 8'd32, 8'd16, 1'b0);
        send(8'd0, 8'd0, 8'd127, 1'b1);
        result("bias_first", 8'd48, 1'b0, 5'd2);

        // Idle gap with in_last but no in_valid must not end the product
        send(8'd32, 8'd64, 8'd0, 1'b0);
        in_last = 1'b1;
        @(posedge clk); #1;
        in_last = 1'b0;
        chk("gap_in_ready", int'(in_ready_m), 1);
        chk("gap_no_valid", int'(out_valid_m), 0);
        send(8'd32, 8'd64, 8'd0, 1'b1);
        result("gap", 8'd64, 1'b0, 5'd2);

        // Output stall: result and flags held while out_ready stays low
        send(8'hc0, 8'd64, 8'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("stall_valid", int'(out_valid_m), 1);
            chk("stall_out", int'(out_m), RELU ? 0 : 8'hc0);
            chk("stall_in_ready", int'(in_ready_m), 0);
            @(posedge clk); #1;
        end
        chk("stall_valid_end", int'(out_valid_m), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall_release", int'(out_valid_m), 0);

        // MAX_TERMS=4 instance: fifth term starts a new product
        sel = 1'b1;
        for (int k = 0; k < 4; k++)
            send(8'd64, 8'd64, 8'd0, 1'b0);
        result("max4_first", 8'h7f, 1'b1, 5'd4);
        send(8'd64, 8'd64, 8'd0, 1'b1);
        result("max4_second", 8'd64, 1'b0, 5'd1);
        sel = 1'b0;

        // Reset mid-product discards the partial sum
        send(8'd64, 8'd64, 8'd0, 1'b0);
        send(8'd64, 8'd64, 8'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", int'(out_valid_m), 0);
        chk("midrst_cnt", int'(cnt_m), 0);
        chk("midrst_out", int'(out_m), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'd64, 8'd64, 8'd0, 1'b1);
        result("after_rst", 8'd64, 1'b0, 5'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
